turn_signal_ctrl: RTL and testbench

TURN_SIGNAL_CTRL -- requirements
Module: turn_signal_ctrl

---
 rtl/turn_signal_pkg.sv | 66 ++++++
 rtl/blink_tick.sv | 35 +++
 rtl/turn_signal_ctrl.sv | 81 ++++++++
 tb/tb_turn_signal_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/turn_signal_pkg.sv
`default_nettype none
// ============================================================================
// Module : turn_signal_pkg
// Brief  : State encoding and lamp patterns shared by the turn-signal block.
// Rev    : 1.0  initial release
// ============================================================================
package turn_signal_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_L1   = 3'd1,
      ST_L2   = 3'd2,
      ST_L3   = 3'd3,
      ST_R1   = 3'd4,
      ST_R2   = 3'd5,
      ST_R3   = 3'd6,
      ST_HZ   = 3'd7
   } state_t;

   // Lamp vectors are ordered {LC, LB, LA, RA, RB, RC}: outer-left to outer-right.
   localparam logic [5:0] C_LAMP_OFF   = 6'b000_000;
   localparam logic [5:0] C_LAMP_L1    = 6'b001_000;
   localparam logic [5:0] C_LAMP_L2    = 6'b011_000;
   localparam logic [5:0] C_LAMP_L3    = 6'b111_000;
   localparam logic [5:0] C_LAMP_R1    = 6'b000_100;
   localparam logic [5:0] C_LAMP_R2    = 6'b000_110;
   localparam logic [5:0] C_LAMP_R3    = 6'b000_111;
   localparam logic [5:0] C_LAMP_ALL   = 6'b111_111;
   localparam logic [5:0] C_LEFT_MASK  = 6'b111_000;
   localparam logic [5:0] C_RIGHT_MASK = 6'b000_111;

   function automatic logic is_left_turn(input state_t s);
      return (s == ST_L1) || (s == ST_L2) || (s == ST_L3);
   endfunction

   function automatic logic is_right_turn(input state_t s);
      return (s == ST_R1) || (s == ST_R2) || (s == ST_R3);
   endfunction

   // Brake lights every lamp on whichever side is not running a sequence.
   function automatic logic [5:0] lamp_pattern(input state_t s, input logic brake);
      logic [5:0] pat;
      pat = C_LAMP_OFF;
      case (s)
         ST_L1:   pat = C_LAMP_L1;
         ST_L2:   pat = C_LAMP_L2;
         ST_L3:   pat = C_LAMP_L3;
         ST_R1:   pat = C_LAMP_R1;
         ST_R2:   pat = C_LAMP_R2;
         ST_R3:   pat = C_LAMP_R3;
         ST_HZ:   pat = C_LAMP_ALL;
         default: pat = C_LAMP_OFF;
      endcase
      if (brake) begin
         if (s == ST_IDLE)
            pat = C_LAMP_ALL;
         else if (is_left_turn(s))
            pat = pat | C_RIGHT_MASK;
         else if (is_right_turn(s))
            pat = pat | C_LEFT_MASK;
      end
      return pat;
   endfunction

endpackage
`default_nettype wire

// File: rtl/blink_tick.sv
`default_nettype none
// ============================================================================
// Module : blink_tick
// Brief  : Free-running prescaler; tick is high on the last count of each period.
// Rev    : 1.0  initial release
// ============================================================================
module blink_tick #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   // A one-bit counter pinned at zero covers TICK_DIV=1, where tick is constant.
   localparam int          c_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [c_W-1:0] c_LAST = c_W'(TICK_DIV - 1);

   logic [c_W-1:0] r_cnt;
   logic           w_wrap;

   assign w_wrap = (r_cnt == c_LAST);
   assign tick   = w_wrap;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_cnt <= '0;
      else if (w_wrap)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + c_W'(1);
   end

endmodule
`default_nettype wire

// File: rtl/turn_signal_ctrl.sv
`default_nettype none
// ============================================================================
// Module : turn_signal_ctrl
// Brief  : Sequential turn / hazard / brake lamp controller, six lamps.
// Rev    : 1.0  initial release
// ============================================================================
module turn_signal_ctrl #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic left,
   input  logic right,
   input  logic hazard,
   input  logic brake,
   output logic LA,
   output logic LB,
   output logic LC,
   output logic RA,
   output logic RB,
   output logic RC
);
   import turn_signal_pkg::*;

   logic       w_tick;
   state_t     r_state;
   state_t     w_next_state;
   logic [5:0] r_lamps;

   blink_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (w_tick)
   );

   always_comb begin
      w_next_state = r_state;
      if (w_tick) begin
         case (r_state)
            ST_IDLE: begin
               if (hazard || (left && right))
                  w_next_state = ST_HZ;
               else if (left)
                  w_next_state = ST_L1;
               else if (right)
                  w_next_state = ST_R1;
            end
            ST_L1:   w_next_state = hazard ? ST_HZ : ST_L2;
            ST_L2:   w_next_state = hazard ? ST_HZ : ST_L3;
            ST_L3:   w_next_state = hazard ? ST_HZ : ST_IDLE;
            ST_R1:   w_next_state = hazard ? ST_HZ : ST_R2;
            ST_R2:   w_next_state = hazard ? ST_HZ : ST_R3;
            ST_R3:   w_next_state = hazard ? ST_HZ : ST_IDLE;
            ST_HZ:   w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
         endcase
      end
   end

   // Lamps decode the upcoming state so they switch on the same edge as it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_lamps <= C_LAMP_OFF;
      end else begin
         r_state <= w_next_state;
         r_lamps <= lamp_pattern(w_next_state, brake);
      end
   end

   assign LC = r_lamps[5];
   assign LB = r_lamps[4];
   assign LA = r_lamps[3];
   assign RA = r_lamps[2];
   assign RB = r_lamps[1];
   assign RC = r_lamps[0];

endmodule
`default_nettype wire

// File: tb/tb_turn_signal_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_turn_signal_ctrl
// Brief  : Self-checking bench, TICK_DIV=4 and TICK_DIV=1 instances side by side.
// Rev    : 1.0  initial release
// ============================================================================
module tb_turn_signal_ctrl;

   localparam int SIDE_NONE  = 0;
   localparam int SIDE_LEFT  = 1;
   localparam int SIDE_RIGHT = 2;
   localparam int SIDE_HAZ   = 3;

   logic clk = 1'b0;
   logic reset, left, right, hazard, brake;
   logic LA4, LB4, LC4, RA4, RB4, RC4;
   logic LA1, LB1, LC1, RA1, RB1, RC1;
   logic [5:0] lamps4, lamps1;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   // Reference: side being signalled, how many lamps lit, and time within the period.
   int         c_div [2] = '{4, 1};
   int         m_cnt [2];
   int         m_side[2];
   int         m_pos [2];
   logic [5:0] m_lamps[2];

   always #5 clk = ~clk;

   assign lamps4 = {LC4, LB4, LA4, RA4, RB4, RC4};
   assign lamps1 = {LC1, LB1, LA1, RA1, RB1, RC1};

   turn_signal_ctrl #(.TICK_DIV(4)) dut4 (
      .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard), .brake(brake),
      .LA(LA4), .LB(LB4), .LC(LC4), .RA(RA4), .RB(RB4), .RC(RC4)
   );

   turn_signal_ctrl #(.TICK_DIV(1)) dut1 (
      .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard), .brake(brake),
      .LA(LA1), .LB(LB1), .LC(LC1), .RA(RA1), .RB(RB1), .RC(RC1)
   );

   function automatic logic [5:0] lamps_from_counts(input int nl, input int nr);
      return {logic'(nl >= 3), logic'(nl >= 2), logic'(nl >= 1),
              logic'(nr >= 1), logic'(nr >= 2), logic'(nr >= 3)};
   endfunction

   function automatic logic [5:0] model_lamps(input int side, input int pos, input logic brk);
      int nl, nr;
      nl = brk ? 3 : 0;
      nr = brk ? 3 : 0;
      if (side == SIDE_LEFT)  nl = pos;
      if (side == SIDE_RIGHT) nr = pos;
      if (side == SIDE_HAZ) begin
         nl = 3;
         nr = 3;
      end
      return lamps_from_counts(nl, nr);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_cnt[k]   = 0;
         m_side[k]  = SIDE_NONE;
         m_pos[k]   = 0;
         m_lamps[k] = 6'b0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         bit tk;
         tk = (m_cnt[k] == c_div[k] - 1);
         m_cnt[k] = (m_cnt[k] + 1) % c_div[k];
         if (tk) begin
            if (m_side[k] == SIDE_NONE) begin
               if (hazard || (left && right)) m_side[k] = SIDE_HAZ;
               else if (left)  begin m_side[k] = SIDE_LEFT;  m_pos[k] = 1; end
               else if (right) begin m_side[k] = SIDE_RIGHT; m_pos[k] = 1; end
            end else if (m_side[k] == SIDE_HAZ) begin
               m_side[k] = SIDE_NONE;
            end else if (hazard) begin
               m_side[k] = SIDE_HAZ;
            end else if (m_pos[k] == 3) begin
               m_side[k] = SIDE_NONE;
            end else begin
               m_pos[k] = m_pos[k] + 1;
            end
         end
         m_lamps[k] = model_lamps(m_side[k], m_pos[k], brake);
      end
   endtask

   task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      check("model_div4", lamps4, m_lamps[0]);
      check("model_div1", lamps1, m_lamps[1]);
   endtask

   // One clock: DUT and reference both see the inputs held since the last negedge.
   task automatic edge_step();
      @(posedge clk);
      if (reset) model_reset();
      else       model_step();
      @(negedge clk);
   endtask

   task automatic restart();
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic set_in(input logic l, input logic r, input logic h, input logic b);
      left = l; right = r; hazard = h; brake = b;
   endtask

   logic [5:0] exp_seq4 [5] = '{6'b001_000, 6'b011_000, 6'b111_000, 6'b000_000, 6'b001_000};
   logic [5:0] exp_seq1 [5] = '{6'b001_000, 6'b011_000, 6'b111_000, 6'b000_000, 6'b001_000};

   initial begin
      reset = 1'b1;
      set_in(0, 0, 0, 0);
      model_reset();
      #3;
      check("reset_div4", lamps4, 6'b0);
      check("reset_div1", lamps1, 6'b0);

      // Left held from reset release: 4-cycle steps vs every-cycle steps.
      restart();
      set_in(1, 0, 0, 0);
      for (int e = 1; e <= 20; e++) begin
         edge_step();
         check_model();
         if (e == 3) check("left_pre_tick", lamps4, 6'b000_000);
         if (e % 4 == 0) check("left_seq_div4", lamps4, exp_seq4[e/4 - 1]);
         if (e <= 5) check("left_seq_div1", lamps1, exp_seq1[e - 1]);
      end

      // Left+right together -> hazard blink 4 on / 4 off.
      restart();
      set_in(1, 1, 0, 0);
      for (int e = 1; e <= 16; e++) begin
         edge_step();
         check_model();
         if (e == 4 || e == 7 || e == 12) check("lr_hazard_on", lamps4, 6'b111_111);
         if (e == 8 || e == 11) check("lr_hazard_off", lamps4, 6'b000_000);
      end

      // Hazard raised during L2 skips L3.
      restart();
      set_in(1, 0, 0, 0);
      for (int e = 1; e <= 12; e++) begin
         edge_step();
         check_model();
         if (e == 9) hazard = 1'b1;
         if (e == 12) check("hazard_preempt", lamps4, 6'b111_111);
      end

      // Brake in idle, then left turn under brake.
      restart();
      set_in(0, 0, 0, 1);
      edge_step();
      check_model();
      check("brake_idle", lamps4, 6'b111_111);
      left = 1'b1;
      for (int e = 2; e <= 12; e++) begin
         edge_step();
         check_model();
         if (e == 4)  check("brake_l1", lamps4, 6'b001_111);
         if (e == 12) check("brake_l3", lamps4, 6'b111_111);
      end

      // Asynchronous reset during R3, then first tick on the 4th edge.
      restart();
      set_in(0, 1, 0, 0);
      for (int e = 1; e <= 13; e++) begin
         edge_step();
         check_model();
      end
      check("r3_lamps", lamps4, 6'b000_111);
      #2 reset = 1'b1;
      #1;
      check("async_reset_div4", lamps4, 6'b0);
      check("async_reset_div1", lamps1, 6'b0);
      model_reset();
      #1 reset = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         edge_step();
         check_model();
         if (e == 3) check("post_reset_quiet", lamps4, 6'b000_000);
         if (e == 4) check("post_reset_tick", lamps4, 6'b000_100);
      end

      // Randomised traffic with occasional mid-cycle reset pulses.
      for (int i = 0; i < 800; i++) begin
         left   = ($urandom_range(0, 99) < 35);
         right  = ($urandom_range(0, 99) < 35);
         hazard = ($urandom_range(0, 99) < 8);
         brake  = ($urandom_range(0, 99) < 30);
         if ($urandom_range(0, 99) < 2) begin
            #2 reset = 1'b1;
            #1;
            check("rand_async_reset", lamps4 | lamps1, 6'b0);
            model_reset();
            #1 reset = 1'b0;
         end
         edge_step();
         check_model();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
